// File: rtl/psum_drain_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : psum_drain_pkg
//  Description : Shared types and constants for the partial-sum drain block:
//                FSM state encoding, default array geometry, psum word type.
//  Revision    : 1.0  initial release
// ============================================================================
package psum_drain_pkg;

    localparam int DEF_ARRAY_SIZE = 8;
    localparam int DEF_COL_WIDTH  = 13;
    localparam int LANES_PER_COL  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // One column psum at the default geometry (four lanes of COL_WIDTH bits)
    typedef logic [DEF_COL_WIDTH*LANES_PER_COL-1:0] psum_word_t;

endpackage
`default_nettype wire

// File: rtl/psum_acc_lane.sv
`default_nettype none
// ============================================================================
//  Module      : psum_acc_lane
//  Description : Single-column accumulator: sign-extends one signed psum and
//                either loads it or adds it to the running total. With
//                PSUM_DRAIN_SAT_EN defined the add clamps at the signed
//                ACC_WIDTH limits and reports the clamp on sat_o.
//  Revision    : 1.0  initial release
// ============================================================================
module psum_acc_lane #(
    parameter int PSUM_W    = 52,
    parameter int ACC_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic                 add_i,
    input  logic [PSUM_W-1:0]    psum_i,
    output logic [ACC_WIDTH-1:0] acc_o
`ifdef PSUM_DRAIN_SAT_EN
    ,
    output logic                 sat_o
`endif
);

    logic [ACC_WIDTH-1:0] ext_w;
    logic [ACC_WIDTH-1:0] sum_w;
    logic [ACC_WIDTH-1:0] acc_d;
    logic [ACC_WIDTH-1:0] acc_q;

    assign ext_w = ACC_WIDTH'($signed(psum_i));
    assign sum_w = acc_q + ext_w;
    assign acc_o = acc_q;

`ifdef PSUM_DRAIN_SAT_EN
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic ovf_w;
    // Overflow only when both operands share a sign and the result flips it
    assign ovf_w = (acc_q[ACC_WIDTH-1] == ext_w[ACC_WIDTH-1]) &&
                   (sum_w[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
    assign sat_o = add_i && ovf_w;
`endif

    // Next accumulator value: load first pass, add (wrap or clamp) afterwards
    always_comb begin
        acc_d = acc_q;
        if (load_i) begin
            acc_d = ext_w;
        end else if (add_i) begin
`ifdef PSUM_DRAIN_SAT_EN
            if (ovf_w) begin
                acc_d = acc_q[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
            end else begin
                acc_d = sum_w;
            end
`else
            acc_d = sum_w;
`endif
        end
    end

    // Accumulator register
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/psum_drain.sv
`default_nettype none
// ============================================================================
//  Module      : psum_drain
//  Description : Sums num_passes psum words per tile across ARRAY_SIZE
//                columns, then drains one column result per handshake.
//                Optional macro PSUM_DRAIN_SAT_EN enables saturating adds
//                and the sticky per-tile sat_flag.
//  Revision    : 1.0  initial release
// ============================================================================
module psum_drain
    import psum_drain_pkg::*;
#(
    parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
    parameter int COL_WIDTH  = DEF_COL_WIDTH,
    parameter int ACC_WIDTH  = 64
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          psum_valid,
    input  logic [ARRAY_SIZE-1:0][COL_WIDTH*LANES_PER_COL-1:0] psums,
    output logic                                          psum_ready,
    input  logic [7:0]                                    num_passes,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [ACC_WIDTH-1:0]                          out_data,
    output logic [$clog2(ARRAY_SIZE)-1:0]                 out_col,
    output logic                                          out_last,
    output logic                                          busy,
    output logic                                          sat_flag
);

    localparam int PSUM_W = COL_WIDTH * LANES_PER_COL;
    localparam int COL_W  = $clog2(ARRAY_SIZE);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(ARRAY_SIZE - 1);

    state_e               state_q, state_d;
    logic [COL_W-1:0]     col_q, col_d;
    logic [7:0]           pass_cnt_q, pass_cnt_d;
    logic [7:0]           passes_q, passes_d;
    logic [7:0]           passes_eff_w;
    logic                 accept_w;
    logic                 load_w;
    logic                 add_w;
    logic [ACC_WIDTH-1:0] acc_w [ARRAY_SIZE];

    assign psum_ready   = !rst && (state_q != ST_DRAIN);
    assign accept_w     = psum_valid && psum_ready;
    assign load_w       = accept_w && (state_q == ST_IDLE);
    assign add_w        = accept_w && (state_q == ST_ACCUM);
    // A zero pass count is treated as a single pass
    assign passes_eff_w = (num_passes == 8'd0) ? 8'd1 : num_passes;

`ifdef PSUM_DRAIN_SAT_EN
    logic [ARRAY_SIZE-1:0] lane_sat_w;
`endif

    generate
        for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_lane
            psum_acc_lane #(
                .PSUM_W    (PSUM_W),
                .ACC_WIDTH (ACC_WIDTH)
            ) u_lane (
                .clk    (clk),
                .rst    (rst),
                .load_i (load_w),
                .add_i  (add_w),
                .psum_i (psums[g]),
                .acc_o  (acc_w[g])
`ifdef PSUM_DRAIN_SAT_EN
                ,
                .sat_o  (lane_sat_w[g])
`endif
            );
        end
    endgenerate

    // Next-state logic for tile sequencing and drain column pointer
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        pass_cnt_d = pass_cnt_q;
        passes_d   = passes_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept_w) begin
                    passes_d   = passes_eff_w;
                    pass_cnt_d = 8'd1;
                    col_d      = '0;
                    state_d    = (passes_eff_w == 8'd1) ? ST_DRAIN : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (accept_w) begin
                    pass_cnt_d = pass_cnt_q + 8'd1;
                    if ((pass_cnt_q + 8'd1) == passes_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    if (col_q == LAST_COL) begin
                        col_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            col_q      <= '0;
            pass_cnt_q <= '0;
            passes_q   <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            pass_cnt_q <= pass_cnt_d;
            passes_q   <= passes_d;
        end
    end

`ifdef PSUM_DRAIN_SAT_EN
    logic sat_flag_q, sat_flag_d;

    // Sticky clamp indicator, cleared when a new tile starts
    always_comb begin
        sat_flag_d = sat_flag_q;
        if (load_w) begin
            sat_flag_d = 1'b0;
        end else if (add_w && (|lane_sat_w)) begin
            sat_flag_d = 1'b1;
        end
    end

    // Saturation flag register
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_flag_q <= 1'b0;
        end else begin
            sat_flag_q <= sat_flag_d;
        end
    end

    assign sat_flag = !rst && sat_flag_q;
`else
    assign sat_flag = 1'b0;
`endif

    // Outputs are forced quiet while reset is held
    assign out_valid = !rst && (state_q == ST_DRAIN);
    assign out_data  = rst ? '0 : acc_w[col_q];
    assign out_col   = rst ? '0 : col_q;
    assign out_last  = out_valid && (col_q == LAST_COL);
    assign busy      = !rst && (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_psum_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_psum_drain
//  Description : Scoreboard bench for psum_drain (ACC_WIDTH = 52, so the
//                accumulator equals the psum width and overflow is reachable).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_psum_drain;
    import psum_drain_pkg::*;

    localparam int AS    = 8;
    localparam int CW    = 13;
    localparam int PW    = CW * 4;
    localparam int ACC_W = 52;

    typedef logic [AS-1:0][PW-1:0] psum_vec_t;
    typedef struct packed {
        logic [ACC_W-1:0] data;
        logic [2:0]       col;
        logic             last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              psum_valid = 1'b0;
    psum_vec_t         psums = '0;
    logic              psum_ready;
    logic [7:0]        num_passes = 8'd0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ACC_W-1:0]  out_data;
    logic [2:0]        out_col;
    logic              out_last;
    logic              busy;
    logic              sat_flag;

    int checks = 0;
    int fails  = 0;

    exp_t             sb[$];
    psum_vec_t        tile_words [4];
    logic [ACC_W-1:0] m_acc [AS];
    bit               m_sat;

    always #5 clk = ~clk;

    psum_drain #(
        .ARRAY_SIZE (AS),
        .COL_WIDTH  (CW),
        .ACC_WIDTH  (ACC_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .psum_valid (psum_valid),
        .psums      (psums),
        .psum_ready (psum_ready),
        .num_passes (num_passes),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_col    (out_col),
        .out_last   (out_last),
        .busy       (busy),
        .sat_flag   (sat_flag)
    );

    // Reference add on a widened signed sum; clamps only in the saturating build
    function automatic logic [ACC_W-1:0] m_add(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
        logic signed [ACC_W:0] w;
        w = $signed({a[ACC_W-1], a}) + $signed({b[ACC_W-1], b});
`ifdef PSUM_DRAIN_SAT_EN
        if (w > $signed({2'b00, {(ACC_W-1){1'b1}}})) begin
            m_sat = 1'b1;
            return {1'b0, {(ACC_W-1){1'b1}}};
        end
        if (w < $signed({2'b11, {(ACC_W-1){1'b0}}})) begin
            m_sat = 1'b1;
            return {1'b1, {(ACC_W-1){1'b0}}};
        end
`endif
        return w[ACC_W-1:0];
    endfunction

    // Drive nwords words of tile_words; push expectations when the tile completes
    task automatic send_tile(input logic [7:0] np, input int nwords, input bit gap);
        int eff;
        eff = (np == 8'd0) ? 1 : int'(np);
        for (int w = 0; w < nwords; w++) begin
            if (gap && w > 0) begin
                @(negedge clk);
                psum_valid = 1'b0;
                checks++;
                if (busy !== 1'b1 || out_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL accum_hold: busy=%0b out_valid=%0b, required busy=1 out_valid=0", busy, out_valid);
                end
            end
            @(negedge clk);
            psum_valid = 1'b1;
            psums      = tile_words[w];
            num_passes = (w == 0) ? np : 8'd2;
            checks++;
            if (psum_ready !== 1'b1) begin
                fails++;
                $display("FAIL in_ready word %0d: got %0b, required 1", w, psum_ready);
            end
            for (int c = 0; c < AS; c++) begin
                if (w == 0) begin
                    m_acc[c] = ACC_W'($signed(tile_words[w][c]));
                    m_sat    = 1'b0;
                end else begin
                    m_acc[c] = m_add(m_acc[c], ACC_W'($signed(tile_words[w][c])));
                end
            end
        end
        @(negedge clk);
        psum_valid = 1'b0;
        if (nwords == eff) begin
            checks++;
            if (out_valid !== 1'b1 || psum_ready !== 1'b0 || out_col !== 3'd0) begin
                fails++;
                $display("FAIL latency: out_valid=%0b psum_ready=%0b out_col=%0d, required 1 0 0",
                         out_valid, psum_ready, out_col);
            end
            checks++;
            if (sat_flag !== m_sat) begin
                fails++;
                $display("FAIL sat_flag: got %0b, required %0b", sat_flag, m_sat);
            end
            for (int c = 0; c < AS; c++) begin
                sb.push_back('{data: m_acc[c], col: 3'(c), last: (c == AS - 1)});
            end
        end else begin
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b1) begin
                fails++;
                $display("FAIL partial_tile: out_valid=%0b busy=%0b, required 0 1", out_valid, busy);
            end
        end
    endtask

    // Consume the scoreboard; optional 1-0-0-1 out_ready pattern
    task automatic drain_tile(input bit stall);
        exp_t             e;
        logic [ACC_W-1:0] held_d;
        logic [2:0]       held_c;
        bit               stalled;
        int               guard;
        int               k;
        stalled = 1'b0;
        guard   = 0;
        k       = 0;
        held_d  = '0;
        held_c  = '0;
        while (sb.size() > 0 && guard < 200) begin
            @(negedge clk);
            guard++;
            out_ready = stall ? ((k % 4) == 0 || (k % 4) == 3) : 1'b1;
            k++;
            #1;
            checks++;
            if (out_valid !== 1'b1 || psum_ready !== 1'b0) begin
                fails++;
                $display("FAIL drain_valid: out_valid=%0b psum_ready=%0b, required 1 0", out_valid, psum_ready);
            end
            if (stalled) begin
                checks++;
                if (out_data !== held_d || out_col !== held_c) begin
                    fails++;
                    $display("FAIL stall_hold: data=%0h col=%0d, required data=%0h col=%0d",
                             out_data, out_col, held_d, held_c);
                end
            end
            if (out_ready) begin
                e = sb.pop_front();
                stalled = 1'b0;
                checks++;
                if (out_data !== e.data || out_col !== e.col || out_last !== e.last) begin
                    fails++;
                    $display("FAIL drain_data: data=%0h col=%0d last=%0b, required data=%0h col=%0d last=%0b",
                             out_data, out_col, out_last, e.data, e.col, e.last);
                end
            end else begin
                stalled = 1'b1;
                held_d  = out_data;
                held_c  = out_col;
            end
        end
        if (sb.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain_timeout: %0d results left, required 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || psum_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL post_drain: out_valid=%0b psum_ready=%0b busy=%0b, required 0 1 0",
                     out_valid, psum_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        psum_valid = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (psum_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0 ||
            out_data !== '0 || out_col !== 3'd0 || sat_flag !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: ready=%0b valid=%0b busy=%0b last=%0b data=%0h col=%0d sat=%0b, required all 0",
                     psum_ready, out_valid, busy, out_last, out_data, out_col, sat_flag);
        end
        psum_valid = 1'b0;
        rst        = 1'b0;
        @(negedge clk);
        checks++;
        if (psum_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: ready=%0b busy=%0b valid=%0b, required 1 0 0", psum_ready, busy, out_valid);
        end
    endtask

    task automatic test_single_pass();
        for (int c = 0; c < AS; c++) tile_words[0][c] = PW'(c + 1);
        send_tile(8'd1, 1, 1'b0);
        drain_tile(1'b0);
    endtask

    task automatic test_multi_pass();
        for (int w = 0; w < 3; w++)
            for (int c = 0; c < AS; c++) tile_words[w][c] = PW'(-5);
        send_tile(8'd3, 3, 1'b1);
        drain_tile(1'b0);
    endtask

    task automatic test_zero_passes();
        for (int c = 0; c < AS; c++) tile_words[0][c] = PW'(c * 100 - 350);
        send_tile(8'd0, 1, 1'b0);
        drain_tile(1'b0);
    endtask

    task automatic test_wrap();
        logic [ACC_W-1:0] exp0;
        for (int w = 0; w < 2; w++)
            for (int c = 0; c < AS; c++) tile_words[w][c] = {1'b0, {(PW-1){1'b1}}};
`ifdef PSUM_DRAIN_SAT_EN
        exp0 = {1'b0, {(ACC_W-1){1'b1}}};
`else
        exp0 = {{(ACC_W-1){1'b1}}, 1'b0};
`endif
        send_tile(8'd2, 2, 1'b0);
        checks++;
        if (out_data !== exp0) begin
            fails++;
            $display("FAIL wrap_value: got %0h, required %0h", out_data, exp0);
        end
        drain_tile(1'b0);
    endtask

    task automatic test_stall();
        psum_word_t v;
        for (int w = 0; w < 2; w++)
            for (int c = 0; c < AS; c++) begin
                v = PW'(int'($urandom_range(0, 2000)) - 1000);
                tile_words[w][c] = v;
            end
        send_tile(8'd2, 2, 1'b0);
        drain_tile(1'b1);
    endtask

    task automatic test_reset_abort();
        for (int w = 0; w < 2; w++)
            for (int c = 0; c < AS; c++) tile_words[w][c] = PW'(w * 10 + c);
        send_tile(8'd4, 2, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if (psum_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL abort_in_reset: ready=%0b busy=%0b valid=%0b, required 0 0 0", psum_ready, busy, out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || psum_ready !== 1'b1) begin
            fails++;
            $display("FAIL abort_idle: busy=%0b valid=%0b ready=%0b, required 0 0 1", busy, out_valid, psum_ready);
        end
        for (int c = 0; c < AS; c++) tile_words[0][c] = PW'(c * 7 + 3);
        send_tile(8'd1, 1, 1'b0);
        drain_tile(1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_pass();
        test_multi_pass();
        test_zero_passes();
        test_wrap();
        test_stall();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/psum_drain.md
PSUM_DRAIN -- requirements
Module: psum_drain

Interface
REQ-001 SHALL have parameter ARRAY_SIZE, default 8, number of array columns drained.
REQ-002 SHALL have parameter COL_WIDTH, default 13, per-lane psum width; a column psum is COL_WIDTH*4 bits.
REQ-003 SHALL have parameter ACC_WIDTH, default 64, accumulator width (SHALL be >= COL_WIDTH*4).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port psum_valid  input  1  psums word valid this cycle.
REQ-007 SHALL have port psums  input  ARRAY_SIZE x (COL_WIDTH*4)  one signed psum per column, from the array's registered output.
REQ-008 SHALL have port psum_ready  output  1  block accepts psums this cycle.
REQ-009 SHALL have port num_passes  input  8  psum words summed per tile; sampled on the first accepted word.
REQ-010 SHALL have port out_valid  output  1  out_data valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-012 SHALL have port out_data  output  ACC_WIDTH  accumulated column result, signed.
REQ-013 SHALL have port out_col  output  $clog2(ARRAY_SIZE)  column index of out_data.
REQ-014 SHALL have port out_last  output  1  high with the final column of a tile.
REQ-015 SHALL have port busy  output  1  high in any state except IDLE.
REQ-016 SHALL have port sat_flag  output  1  sticky per tile; saturation occurred.

Function
REQ-017 SHALL implement the FSM states IDLE, ACCUM and DRAIN.
REQ-018 Input handshake: a psum word is accepted when psum_valid and psum_ready are both high; psum_ready SHALL be 1 in IDLE/ACCUM and 0 in DRAIN.
REQ-019 IDLE, on accept: latch passes = (num_passes==0 ? 1 : num_passes); acc[c] = sign-extended psums[c]; pass_cnt = 1; next state DRAIN if passes==1, else ACCUM; clear sat_flag.
REQ-020 ACCUM, on accept: acc[c] += sign-extended psums[c] for all c in the same cycle; pass_cnt++; when pass_cnt reaches passes, go to DRAIN next cycle.
REQ-021 ACCUM with psum_valid low: hold all state; there is no timeout.
REQ-022 DRAIN: out_valid=1, out_data=acc[col], out_col=col, out_last=(col==ARRAY_SIZE-1); col starts at 0.
REQ-023 DRAIN: col advances only on out_valid&&out_ready; out_data/out_col SHALL hold stable while out_ready is low.
REQ-024 DRAIN: handshake with out_last SHALL return to IDLE; psum_ready rises the next cycle.
REQ-025 Latency: first out_valid SHALL appear 1 cycle after the accept that completes the tile.
REQ-026 Arithmetic wraps modulo 2^ACC_WIDTH unless REQ-031 applies.
REQ-027 num_passes changes after the first accept SHALL have no effect on the current tile.
REQ-028 out_valid SHALL be 0 in IDLE/ACCUM.

Reset
REQ-029 While rst=1: state=IDLE, col=0, pass_cnt=0, acc=0, sat_flag=0, out_valid=0, out_last=0, busy=0, psum_ready=0; out_data=0, out_col=0.
REQ-030 rst mid-ACCUM or mid-DRAIN SHALL abort the tile with no further outputs; the next tile starts clean.

Configuration
REQ-031 Macro PSUM_DRAIN_SAT_EN defined: each add SHALL saturate at the signed ACC_WIDTH min/max and set sat_flag; undefined: adds wrap and sat_flag is tied 0.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the default ARRAY_SIZE and COL_WIDTH constants, and a psum-word typedef.
REQ-033 One sub-module, psum_acc_lane (single-column sign-extend plus add, with optional saturation), SHALL be instantiated ARRAY_SIZE times.

Verification
REQ-034 num_passes=1, psums[c]=c+1 -> 8 outputs 1..8, out_col 0..7, out_last only on col 7, first out_valid 1 cycle after accept.
REQ-035 num_passes=3, psums[c]=-5 each pass -> all outputs -15; psum_ready low throughout DRAIN.
REQ-036 num_passes=0 -> behaves as 1 pass.
REQ-037 out_ready toggled 1-0-0-1 during DRAIN -> no duplicate or skipped column; data held stable while stalled.
REQ-038 rst asserted at pass 2 of 4 -> IDLE next cycle, out_valid 0; a fresh 1-pass tile then drains correctly.
REQ-039 With PSUM_DRAIN_SAT_EN, ACC_WIDTH=52, 2 passes of max positive psum -> output = 2^51-1, sat_flag=1; without the macro -> wrapped value, sat_flag=0.
